// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86 SEQ datapath: steps each instruction
// through its stages, handles memory handshakes/timeouts, status and retire count.
module seq_stage_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_WID     = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic [3:0]         icode,
    input  logic               Cnd,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    input  logic               dmem_err,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               dmem_wr,
    output logic               fetch_en,
    output logic               decode_en,
    output logic               exec_en,
    output logic               cc_en,
    output logic               wb_en,
    output logic               pc_en,
    output logic [1:0]         pc_sel,
    output logic [3:0]         stat,
    output logic               busy,
    output logic [CNT_WID-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALT
    } state_t;

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;

    // Last cycle a request may wait; no ack here means a timeout fault.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_WID-1:0] CNT_ONE = {{(CNT_WID-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [3:0]         stat_q, stat_d;
    logic [CNT_WID-1:0] retired_q, retired_d;
    logic [7:0]         tmo_q, tmo_d;

    logic needs_mem, mem_write, wb_after_mem, wb_no_mem;

    always_comb begin
        needs_mem    = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        mem_write    = icode inside {4'h4, 4'h8, 4'hA};
        wb_after_mem = icode inside {4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        wb_no_mem    = icode inside {4'h2, 4'h3, 4'h6};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            stat_q    <= STAT_AOK;
            retired_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stat_d    = stat_q;
        retired_d = retired_q;
        tmo_d     = tmo_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_wr   = 1'b0;
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        cc_en     = 1'b0;
        wb_en     = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = 2'd0;
        busy      = (state_q != S_IDLE) && (state_q != S_HALT);

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_FETCH;
                    tmo_d   = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    fetch_en = 1'b1;
                    state_d  = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DECODE: begin
                decode_en = 1'b1;
                if (icode == 4'h0) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                end else if (icode > 4'hB) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_en = 1'b1;
                cc_en   = (icode == 4'h6);
                if (needs_mem) begin
                    state_d = S_MEM;
                    tmo_d   = '0;
                end else if (wb_no_mem) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_PCUPD;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_wr  = mem_write;
                // An ack on the final timeout cycle still wins over the fault.
                if (dmem_ack) begin
                    if (dmem_err) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = wb_after_mem ? S_WB : S_PCUPD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WB: begin
                wb_en   = 1'b1;
                state_d = S_PCUPD;
            end
            S_PCUPD: begin
                pc_en     = 1'b1;
                retired_d = retired_q + CNT_ONE;
                state_d   = S_FETCH;
                tmo_d     = '0;
                if (icode == 4'h9)
                    pc_sel = 2'd2;
                else if ((icode == 4'h8) || ((icode == 4'h7) && Cnd))
                    pc_sel = 2'd1;
                else
                    pc_sel = 2'd0;
            end
            S_HALT: begin
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stat    = stat_q;
    assign retired = retired_q;

endmodule
